// File: rtl/pushbutton_debouncer.sv
// pushbutton_debouncer
// Per-channel button conditioner. Each channel has a two-flop synchronizer,
// a debounce state machine with a stable-sample counter, and a repeat timer.
// The outputs are a debounced level (DPBs), a single pulse per accepted
// press (SCENs) and an auto-repeat pulse train while the button is held
// (MCENs). Every output comes straight from a flop.

module pushbutton_debouncer #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] PBs,
  output logic [N_BTN-1:0] DPBs,
  output logic [N_BTN-1:0] SCENs,
  output logic [N_BTN-1:0] MCENs
);

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1. The repeat
  // counter is sized for the larger of its two reload values.
  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_DELAY  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RCNT_PERIOD = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;

  // Two-flop synchronizer for the raw, asynchronous button levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= PBs;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [RCNT_W-1:0] rcnt_reg, rcnt_next;
    logic              dpb_reg, dpb_next;
    logic              scen_reg, scen_next;
    logic              mcen_reg, mcen_next;
    logic              s;

    assign s = sync2_reg[gi];

    // State, debounce counter and repeat counter registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        rcnt_reg  <= '0;
        dpb_reg   <= 1'b0;
        scen_reg  <= 1'b0;
        mcen_reg  <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        rcnt_reg  <= rcnt_next;
        dpb_reg   <= dpb_next;
        scen_reg  <= scen_next;
        mcen_reg  <= mcen_next;
      end
    end

    // Next-state logic. The repeat counter is left alone in REL_CHK so that
    // a short release bounce does not disturb the repeat schedule.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      rcnt_next  = rcnt_reg;
      case (state_reg)
        IDLE: begin
          if (s) begin
            state_next = PRESS_CHK;
            cnt_next   = '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state_next = IDLE;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = HELD;
            rcnt_next  = RCNT_DELAY;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        HELD: begin
          if (!s) begin
            state_next = REL_CHK;
            cnt_next   = '0;
          end else if (rcnt_reg == '0) begin
            rcnt_next = RCNT_PERIOD;
          end else begin
            rcnt_next = rcnt_reg - 1'b1;
          end
        end
        REL_CHK: begin
          if (s) begin
            state_next = HELD;
          end else if (cnt_reg == CNT_LAST) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Output logic, computed from the transition so the flopped outputs line
    // up with the first cycle spent in the new state.
    always_comb begin
      dpb_next  = (state_next == HELD) || (state_next == REL_CHK);
      scen_next = (state_reg == PRESS_CHK) && (state_next == HELD);
      mcen_next = scen_next ||
                  ((state_reg == HELD) && s && (rcnt_reg == '0));
    end

    assign DPBs[gi]  = dpb_reg;
    assign SCENs[gi] = scen_reg;
    assign MCENs[gi] = mcen_reg;
  end

endmodule

// File: doc/pushbutton_debouncer.md
Name: pushbutton_debouncer

Overview:
- Multi-channel pushbutton conditioner. Produces the debounced levels (DPBs), single-clock-enable pulses (SCENs) and auto-repeat pulses (MCENs) that Game_Logic and the menu logic consume.
- Sits between the raw board buttons and the game logic, in the game logic's clock domain.
- Each channel runs an independent synchronizer, a debounce state machine and a repeat timer.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a press or a release. Must be >= 1.
- REPEAT_DELAY, 25000000, cycles from the first MCEN pulse to the second MCEN pulse while held. Must be >= 1.
- REPEAT_PERIOD, 5000000, cycles between later MCEN pulses while held. Must be >= 1.

Ports:
- clk  input  1  system clock; every flop is on posedge clk.
- reset  input  1  synchronous, active-high reset.
- PBs  input  N_BTN  raw asynchronous button levels, 1 = pressed.
- DPBs  output  N_BTN  debounced level per channel.
- SCENs  output  N_BTN  one-cycle pulse per accepted press.
- MCENs  output  N_BTN  one-cycle pulse on press, then auto-repeat while held.

Behaviour:
- One clock: clk. Reset is synchronous and active-high, named reset. All outputs are registered.
- Reset: sync flops = 0, every channel in IDLE, all counters = 0. DPBs, SCENs and MCENs = 0 in the cycle after the edge that samples reset=1. Reset overrides every other event.
- Synchronizer: two flops per channel. The synchronized signal s is PBs delayed by 2 edges.
- Per-channel FSM: IDLE, PRESS_CHK, HELD, REL_CHK. Counter cnt has width $clog2(DEBOUNCE_CYCLES+1).
- IDLE: DPB = 0.
  - s = 1 -> go to PRESS_CHK, cnt = 0.
- PRESS_CHK: DPB = 0.
  - s = 0 -> go to IDLE.
  - s = 1 and cnt == DEBOUNCE_CYCLES-1 -> go to HELD.
  - otherwise cnt += 1.
- Entering HELD from PRESS_CHK:
  - DPB = 1, SCEN = 1 and MCEN = 1 for exactly that first HELD cycle.
  - Repeat counter rcnt loads REPEAT_DELAY-1.
- HELD: DPB = 1.
  - s = 0 -> go to REL_CHK, cnt = 0, rcnt frozen.
  - Otherwise, when rcnt == 0: MCEN pulses for one cycle and rcnt reloads REPEAT_PERIOD-1.
  - Otherwise rcnt -= 1.
- REL_CHK: DPB stays 1; no SCEN or MCEN.
  - s = 1 -> return to HELD. No SCEN and no MCEN on re-entry; rcnt resumes from its frozen value.
  - s = 0 and cnt == DEBOUNCE_CYCLES-1 -> go to IDLE, DPB = 0.
  - otherwise cnt += 1.
- Press latency:
  - PBs high continuously from the sampling edge k -> DPB rises and SCEN/MCEN pulse in the cycle after edge k+DEBOUNCE_CYCLES+2.
  - Release latency is the same: DPB falls after edge j+DEBOUNCE_CYCLES+2, where j is the first edge that samples PBs = 0.
- Glitch rejection: a high pulse on s lasting fewer than DEBOUNCE_CYCLES+1 samples produces no output. A low bounce on s during HELD lasting fewer than DEBOUNCE_CYCLES samples leaves DPB = 1 and creates no new SCEN.
- SCEN fires exactly once per accepted press; MCEN is never high outside HELD.
- Channels are fully independent. Simultaneous presses on different channels give simultaneous, independent pulses, with no priority logic.
- Reset mid-press: outputs clear and the sync flops clear. A button still held needs the full 2+DEBOUNCE_CYCLES latency again and then produces a fresh SCEN.
- Counter widths are sized with $clog2 of the largest parameter. Counters never wrap, because every compare is exact-equal followed by a reload or a state change.

Test Plan (use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, N_BTN=4):
- Clean press: PBs[0] rises at edge 0 and is held -> DPBs[0] = 1 and SCENs[0] = MCENs[0] = 1 in the cycle after edge 6 only. SCENs[0] stays 0 for the rest of the hold.
- Auto-repeat: the same press held for 40 cycles -> MCENs[0] pulses in the cycles after edges 6, 16, 21, 26, 31, 36 (one cycle each).
- Glitch: PBs[1] high for 3 cycles, then low -> DPBs[1], SCENs[1] and MCENs[1] stay 0 throughout.
- Release bounce and release:
  - While held, PBs[2] drops for 2 cycles and then returns high -> DPBs[2] stays 1, no extra SCEN, and the repeat schedule resumes.
  - A clean release at edge j -> DPBs[2] = 0 after edge j+6.
- Reset mid-hold: reset pulses for 1 cycle at edge 20 while PBs[3] is held -> all outputs 0 from the next cycle. SCENs[3] pulses again 7 cycles after reset deasserts.
- Simultaneous press: PBs = 4'b1111 at edge 0 -> SCENs = 4'b1111 in the same cycle (after edge 6).
